store_write_buffer: RTL and testbench

//  Posted-store FIFO between the EX/MEM boundary and the data memory port.

---
 rtl/store_write_buffer_if.sv | 35 +++
 rtl/store_write_buffer.sv | 115 +++++++++++
 tb/tb_store_write_buffer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// Bus bundle between the store/load pipeline, the store write buffer and the data memory port.
// The master modport is the pipeline/memory side that drives requests; the slave modport is the buffer.
interface store_write_buffer_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  st_valid;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  full;

  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  take_wb;
  logic                  ld_fwd_valid;
  logic [DATA_WIDTH-1:0] ld_data;

  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;

  logic                  flush_req;
  logic                  flush_done;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ready, flush_req,
    input  full, take_wb, ld_fwd_valid, ld_data, mem_valid, mem_addr, mem_data, flush_done
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ready, flush_req,
    output full, take_wb, ld_fwd_valid, ld_data, mem_valid, mem_addr, mem_data, flush_done
  );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-store FIFO: accepts stores in one cycle, drains them to memory in program order,
// forwards the youngest buffered store to loads, and supports a drain-and-report flush.
module store_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {NORMAL, FLUSH} state_t;

  state_t                state_reg, state_next;
  logic [PW-1:0]         head_reg, tail_reg;
  logic [PW:0]           count_reg;
  logic [DEPTH-1:0]      valid_reg;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PW-1:0]         idx;
  logic                  flush_done;

  // Registered count keeps a same-cycle pop from opening space for a push.
  assign full      = (count_reg == (PW+1)'(DEPTH)) || (state_reg == FLUSH);
  assign push      = bus.st_valid & ~full;
  assign pop       = bus.mem_valid & bus.mem_ready;

  assign bus.full       = full;
  assign bus.mem_valid  = (count_reg != '0);
  assign bus.mem_addr   = addr_mem[head_reg];
  assign bus.mem_data   = data_mem[head_reg];
  assign bus.take_wb    = hit;
  assign bus.ld_fwd_valid = hit;
  assign bus.ld_data    = fwd_data;
  assign bus.flush_done = flush_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= bus.st_addr;
      data_mem[tail_reg] <= bus.st_data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst)
          valid_reg[gi] <= 1'b0;
        else if (push && (tail_reg == PW'(gi)))
          valid_reg[gi] <= 1'b1;
        else if (pop && (head_reg == PW'(gi)))
          valid_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_reg + PW'(i);
      if (bus.ld_valid && valid_reg[idx] && (addr_mem[idx] == bus.ld_addr)) begin
        hit      = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= NORMAL;
    else     state_reg <= state_next;
  end

  // Once entered, FLUSH runs to empty regardless of the request level.
  always_comb begin
    state_next = state_reg;
    flush_done = 1'b0;
    case (state_reg)
      NORMAL: if (bus.flush_req) state_next = FLUSH;
      FLUSH: begin
        if (count_reg == '0) begin
          flush_done = 1'b1;
          state_next = NORMAL;
        end
      end
      default: state_next = NORMAL;
    endcase
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// Randomised and directed stimulus against a queue-based reference model of the store write buffer.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 26;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t exp_q[$];
  bit   flushing = 0;
  bit   started  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: compare DUT outputs against the model, then advance the model by one clock.
  always @(negedge clk) begin
    bit            exp_full;
    bit            exp_hit;
    logic [DW-1:0] exp_ld;
    bit            popped;
    exp_full = (exp_q.size() == DEPTH) || flushing;
    exp_hit  = 0;
    exp_ld   = '0;
    popped   = 0;
    if (bus.ld_valid) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].a == bus.ld_addr) begin
          exp_hit = 1;
          exp_ld  = exp_q[i].d;
          break;
        end
      end
    end
    if (started && !rst) begin
      check("full", 64'(bus.full), 64'(exp_full));
      check("mem_valid", 64'(bus.mem_valid), 64'(exp_q.size() != 0));
      check("take_wb", 64'(bus.take_wb), 64'(exp_hit));
      check("ld_fwd_valid", 64'(bus.ld_fwd_valid), 64'(exp_hit));
      if (exp_hit) check("ld_data", 64'(bus.ld_data), 64'(exp_ld));
      check("flush_done", 64'(bus.flush_done), 64'(flushing && exp_q.size() == 0));
      if (bus.mem_valid && bus.mem_ready && exp_q.size() != 0) begin
        check("mem_addr", 64'(bus.mem_addr), 64'(exp_q[0].a));
        check("mem_data", 64'(bus.mem_data), 64'(exp_q[0].d));
        $display("beat addr=%0h data=%0h", bus.mem_addr, bus.mem_data);
      end
    end
    if (rst) begin
      started = 1;
      exp_q.delete();
      flushing = 0;
    end else if (started) begin
      if (exp_q.size() != 0 && bus.mem_ready) popped = 1;
      if (flushing && exp_q.size() == 0) flushing = 0;
      else if (!flushing && bus.flush_req) flushing = 1;
      if (popped) void'(exp_q.pop_front());
      if (bus.st_valid && !exp_full) exp_q.push_back('{a: bus.st_addr, d: bus.st_data});
    end
  end

  task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input logic lv, input logic [AW-1:0] la, input logic rdy,
                      input logic fl, input logic r);
    bus.st_valid  = sv;
    bus.st_addr   = sa;
    bus.st_data   = sd;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.mem_ready = rdy;
    bus.flush_req = fl;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, rdy, 0, 0);
  endtask

  initial begin
    step(0, '0, '0, 0, '0, 0, 0, 1);
    step(0, '0, '0, 0, '0, 0, 0, 1);
    idle(3, 0);

    // Duplicate addresses: youngest wins, other address misses.
    step(1, 26'h10, 32'hAAAA, 0, '0, 0, 0, 0);
    step(1, 26'h10, 32'hBBBB, 0, '0, 0, 0, 0);
    step(0, '0, '0, 1, 26'h10, 0, 0, 0);
    step(0, '0, '0, 1, 26'h14, 0, 0, 0);
    idle(3, 1);

    // Fill to DEPTH, fifth push refused, then drain in order.
    for (int i = 0; i < 5; i++) step(1, 26'h20 + 26'(i), 32'h100 + 32'(i), 0, '0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, '0, '0, 1, 26'h22, 1, 0, 0);

    // Simultaneous push and pop at count 2, enough to wrap the pointers.
    step(1, 26'h30, 32'h300, 0, '0, 0, 0, 0);
    step(1, 26'h31, 32'h301, 0, '0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 26'h40 + 26'(i), 32'h400 + 32'(i), 1, 26'h40 + 26'(i), 1, 0, 0);
    idle(4, 1);

    // Flush with three entries; pushes during the flush must be refused.
    for (int i = 0; i < 3; i++) step(1, 26'h50 + 26'(i), 32'h500 + 32'(i), 0, '0, 0, 0, 0);
    step(0, '0, '0, 0, '0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 26'h60, 32'h600, 1, 26'h52, 1, 0, 0);
    idle(2, 1);
    step(0, '0, '0, 0, '0, 0, 1, 0);
    idle(3, 0);

    // Reset while a beat is pending drops everything.
    step(1, 26'h70, 32'h700, 0, '0, 0, 0, 0);
    step(1, 26'h71, 32'h701, 0, '0, 0, 0, 0);
    step(0, '0, '0, 0, '0, 0, 0, 1);
    step(0, '0, '0, 1, 26'h70, 0, 0, 0);
    idle(2, 0);

    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 26'h10 + 26'($urandom_range(0, 5)), $urandom,
           1'($urandom_range(0, 1)), 26'h10 + 26'($urandom_range(0, 5)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 199) == 0));
    end
    idle(10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
